// File: rtl/of_stage_fwd.sv
// rtl/of_stage_fwd.sv - operand-fetch stage with EX/MEM forwarding, load-use stall and output register
// Decodes register addresses, forwards results, extends immediates and holds one packet for EX.
module of_stage_fwd #(
  parameter int XLEN = 32,
  parameter int NREG = 16,
  parameter int CNTW = 16,
  localparam int AW  = $clog2(NREG)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              If_Valid_i,
  input  logic [XLEN-1:0]   If_Pc_i,
  input  logic [31:0]       If_Instr_i,
  output logic              If_Ready_o,
  output logic [4:0]        Cu_Opcode,
  output logic              Cu_Imm,
  input  logic              Cu_IsImm_i,
  input  logic              Cu_IsSt_i,
  input  logic              Cu_IsLd_i,
  input  logic              Cu_IsRet_i,
  output logic [AW-1:0]     Rd_Addr1,
  output logic [AW-1:0]     Rd_Addr2,
  input  logic [XLEN-1:0]   Rd_Data1,
  input  logic [XLEN-1:0]   Rd_Data2,
  input  logic              Ex_Wr_i,
  input  logic [AW-1:0]     Ex_Rd_i,
  input  logic [XLEN-1:0]   Ex_Data_i,
  input  logic              Ex_IsLd_i,
  input  logic              Mem_Wr_i,
  input  logic [AW-1:0]     Mem_Rd_i,
  input  logic [XLEN-1:0]   Mem_Data_i,
  input  logic              Flush_i,
  output logic              Of_Valid_o,
  input  logic              Of_Ready_i,
  output logic [XLEN-1:0]   Of_Pc_o,
  output logic [31:0]       Of_Instr_o,
  output logic [XLEN-1:0]   Of_A_o,
  output logic [XLEN-1:0]   Of_B_o,
  output logic [XLEN-1:0]   Of_Op2_o,
  output logic [3:0]        Of_Ctrl_o,
  output logic [CNTW-1:0]   Hz_Cnt_o
);

  logic [XLEN-1:0] op1_fwd;
  logic [XLEN-1:0] op2_fwd;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] b_sel;
  logic            hazard;
  logic            load_en;

  always_comb begin
    Cu_Opcode = 5'd0;
    Cu_Imm    = 1'b0;
    Rd_Addr1  = '0;
    Rd_Addr2  = '0;
    if (If_Valid_i) begin
      Cu_Opcode = If_Instr_i[31:27];
      Cu_Imm    = If_Instr_i[26];
      Rd_Addr1  = Cu_IsRet_i ? AW'(NREG - 1) : AW'(If_Instr_i[21:18]);
      Rd_Addr2  = Cu_IsSt_i ? AW'(If_Instr_i[25:22]) : AW'(If_Instr_i[17:14]);
    end
  end

  // A load still in EX has no result yet, so it never forwards from EX.
  always_comb begin
    op1_fwd = Rd_Data1;
    if (Ex_Wr_i && !Ex_IsLd_i && (Ex_Rd_i == Rd_Addr1))
      op1_fwd = Ex_Data_i;
    else if (Mem_Wr_i && (Mem_Rd_i == Rd_Addr1))
      op1_fwd = Mem_Data_i;

    op2_fwd = Rd_Data2;
    if (Ex_Wr_i && !Ex_IsLd_i && (Ex_Rd_i == Rd_Addr2))
      op2_fwd = Ex_Data_i;
    else if (Mem_Wr_i && (Mem_Rd_i == Rd_Addr2))
      op2_fwd = Mem_Data_i;
  end

  always_comb begin
    imm_ext = XLEN'(If_Instr_i[15:0]);
    case (If_Instr_i[17:16])
      2'b00:   imm_ext = XLEN'($signed(If_Instr_i[15:0]));
      2'b10:   imm_ext = ~XLEN'(16'hFFFF) | XLEN'(If_Instr_i[15:0]);
      default: imm_ext = XLEN'(If_Instr_i[15:0]);
    endcase
    b_sel = Cu_IsImm_i ? imm_ext : op2_fwd;
  end

  // Op2 only matters for register-form or store instructions.
  assign hazard = If_Valid_i && Ex_Wr_i && Ex_IsLd_i &&
                  ((Ex_Rd_i == Rd_Addr1) ||
                   ((!Cu_IsImm_i || Cu_IsSt_i) && (Ex_Rd_i == Rd_Addr2)));

  assign load_en    = !Of_Valid_o || Of_Ready_i;
  assign If_Ready_o = Flush_i || (load_en && !hazard);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Of_Valid_o <= 1'b0;
      Of_Pc_o    <= '0;
      Of_Instr_o <= '0;
      Of_A_o     <= '0;
      Of_B_o     <= '0;
      Of_Op2_o   <= '0;
      Of_Ctrl_o  <= '0;
      Hz_Cnt_o   <= '0;
    end else begin
      if (Flush_i)
        Of_Valid_o <= 1'b0;
      else if (load_en)
        Of_Valid_o <= If_Valid_i && !hazard;

      if (load_en) begin
        Of_Pc_o    <= If_Pc_i;
        Of_Instr_o <= If_Instr_i;
        Of_A_o     <= op1_fwd;
        Of_B_o     <= b_sel;
        Of_Op2_o   <= op2_fwd;
        Of_Ctrl_o  <= {Cu_IsImm_i, Cu_IsSt_i, Cu_IsLd_i, Cu_IsRet_i};
      end

      if (hazard && !Flush_i && !(&Hz_Cnt_o))
        Hz_Cnt_o <= Hz_Cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_of_stage_fwd.sv
// tb/tb_of_stage_fwd.sv - scoreboard bench for of_stage_fwd
// Directed vectors push expected packets; a monitor pops them on each output handshake.
module tb_of_stage_fwd;

  localparam int XLEN = 32;
  localparam int NREG = 16;
  localparam int CNTW = 3;
  localparam int AW   = 4;

  logic            Clk = 1'b0;
  logic            Rst;
  logic            If_Valid_i;
  logic [31:0]     If_Pc_i;
  logic [31:0]     If_Instr_i;
  logic            If_Ready_o;
  logic [4:0]      Cu_Opcode;
  logic            Cu_Imm;
  logic            Cu_IsImm_i, Cu_IsSt_i, Cu_IsLd_i, Cu_IsRet_i;
  logic [AW-1:0]   Rd_Addr1, Rd_Addr2;
  logic [31:0]     Rd_Data1, Rd_Data2;
  logic            Ex_Wr_i;
  logic [AW-1:0]   Ex_Rd_i;
  logic [31:0]     Ex_Data_i;
  logic            Ex_IsLd_i;
  logic            Mem_Wr_i;
  logic [AW-1:0]   Mem_Rd_i;
  logic [31:0]     Mem_Data_i;
  logic            Flush_i;
  logic            Of_Valid_o;
  logic            Of_Ready_i;
  logic [31:0]     Of_Pc_o, Of_Instr_o, Of_A_o, Of_B_o, Of_Op2_o;
  logic [3:0]      Of_Ctrl_o;
  logic [CNTW-1:0] Hz_Cnt_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] op2;
    logic [3:0]  ctrl;
  } pkt_t;

  pkt_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   pushed = 0;
  int   popped = 0;

  of_stage_fwd #(.XLEN(XLEN), .NREG(NREG), .CNTW(CNTW)) dut (
    .Clk(Clk), .Rst(Rst),
    .If_Valid_i(If_Valid_i), .If_Pc_i(If_Pc_i), .If_Instr_i(If_Instr_i), .If_Ready_o(If_Ready_o),
    .Cu_Opcode(Cu_Opcode), .Cu_Imm(Cu_Imm),
    .Cu_IsImm_i(Cu_IsImm_i), .Cu_IsSt_i(Cu_IsSt_i), .Cu_IsLd_i(Cu_IsLd_i), .Cu_IsRet_i(Cu_IsRet_i),
    .Rd_Addr1(Rd_Addr1), .Rd_Addr2(Rd_Addr2), .Rd_Data1(Rd_Data1), .Rd_Data2(Rd_Data2),
    .Ex_Wr_i(Ex_Wr_i), .Ex_Rd_i(Ex_Rd_i), .Ex_Data_i(Ex_Data_i), .Ex_IsLd_i(Ex_IsLd_i),
    .Mem_Wr_i(Mem_Wr_i), .Mem_Rd_i(Mem_Rd_i), .Mem_Data_i(Mem_Data_i),
    .Flush_i(Flush_i),
    .Of_Valid_o(Of_Valid_o), .Of_Ready_i(Of_Ready_i),
    .Of_Pc_o(Of_Pc_o), .Of_Instr_o(Of_Instr_o), .Of_A_o(Of_A_o), .Of_B_o(Of_B_o),
    .Of_Op2_o(Of_Op2_o), .Of_Ctrl_o(Of_Ctrl_o), .Hz_Cnt_o(Hz_Cnt_o)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    If_Valid_i = 0; If_Pc_i = 0; If_Instr_i = 0;
    Cu_IsImm_i = 0; Cu_IsSt_i = 0; Cu_IsLd_i = 0; Cu_IsRet_i = 0;
    Rd_Data1 = 0; Rd_Data2 = 0;
    Ex_Wr_i = 0; Ex_Rd_i = 0; Ex_Data_i = 0; Ex_IsLd_i = 0;
    Mem_Wr_i = 0; Mem_Rd_i = 0; Mem_Data_i = 0;
    Flush_i = 0; Of_Ready_i = 1;
  endtask

  // ctrl = {IsImm, IsSt, IsLd, IsRet}
  task automatic issue(input logic [31:0] pc, input logic [31:0] instr, input logic [3:0] ctrl,
                       input logic [31:0] rd1, input logic [31:0] rd2);
    If_Valid_i = 1; If_Pc_i = pc; If_Instr_i = instr;
    {Cu_IsImm_i, Cu_IsSt_i, Cu_IsLd_i, Cu_IsRet_i} = ctrl;
    Rd_Data1 = rd1; Rd_Data2 = rd2;
  endtask

  task automatic expect_pkt(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] op2, input logic [3:0] ctrl);
    pkt_t p;
    p.pc = pc; p.instr = instr; p.a = a; p.b = b; p.op2 = op2; p.ctrl = ctrl;
    exp_q.push_back(p);
    pushed++;
  endtask

  // Monitor: the packet is taken by EX at the next rising edge.
  initial begin
    pkt_t p;
    forever begin
      @(negedge Clk);
      if (!Rst && Of_Valid_o && Of_Ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pkt_pc", Of_Pc_o, 32'hFFFF_FFFF);
        end else begin
          p = exp_q.pop_front();
          popped++;
          chk("pkt_pc", Of_Pc_o, p.pc);
          chk("pkt_instr", Of_Instr_o, p.instr);
          chk("pkt_a", Of_A_o, p.a);
          chk("pkt_b", Of_B_o, p.b);
          chk("pkt_op2", Of_Op2_o, p.op2);
          chk("pkt_ctrl", 32'(Of_Ctrl_o), 32'(p.ctrl));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clr();
    Rst = 1;
    #2;
    chk("rst_valid", 32'(Of_Valid_o), 32'd0);
    chk("rst_hz", 32'(Hz_Cnt_o), 32'd0);
    chk("rst_a", Of_A_o, 32'd0);
    chk("rst_pc", Of_Pc_o, 32'd0);
    repeat (2) @(posedge Clk);
    #1 Rst = 0;
    @(negedge Clk);
    chk("rst_if_ready", 32'(If_Ready_o), 32'd1);
    step();

    // Plain register op, rs1=2 rs2=3
    issue(32'h100, 32'h0808_C000, 4'b0000, 32'd5, 32'd7);
    expect_pkt(32'h100, 32'h0808_C000, 32'd5, 32'd7, 32'd7, 4'b0000);
    @(negedge Clk);
    chk("dec_addr1", 32'(Rd_Addr1), 32'd2);
    chk("dec_addr2", 32'(Rd_Addr2), 32'd3);
    chk("dec_opcode", 32'(Cu_Opcode), 32'd1);
    chk("dec_imm", 32'(Cu_Imm), 32'd0);
    step();
    chk("reg_op_valid", 32'(Of_Valid_o), 32'd1);

    // Immediate extension modes 00/01/10/11 on imm=8001
    issue(32'h104, 32'h1004_8001, 4'b1000, 32'h11, 32'h22);
    expect_pkt(32'h104, 32'h1004_8001, 32'h11, 32'hFFFF_8001, 32'h22, 4'b1000);
    step();
    issue(32'h108, 32'h1005_8001, 4'b1000, 32'h11, 32'h22);
    expect_pkt(32'h108, 32'h1005_8001, 32'h11, 32'h0000_8001, 32'h22, 4'b1000);
    step();
    issue(32'h10C, 32'h1006_8001, 4'b1000, 32'h11, 32'h22);
    expect_pkt(32'h10C, 32'h1006_8001, 32'h11, 32'hFFFF_8001, 32'h22, 4'b1000);
    step();
    issue(32'h110, 32'h1007_8001, 4'b1000, 32'h11, 32'h22);
    expect_pkt(32'h110, 32'h1007_8001, 32'h11, 32'h0000_8001, 32'h22, 4'b1000);
    step();

    // Return + store addressing: rs1 forced to 15, rs2 from [25:22]=5
    issue(32'h114, 32'h1D48_0000, 4'b0101, 32'h33, 32'h44);
    expect_pkt(32'h114, 32'h1D48_0000, 32'h33, 32'h44, 32'h44, 4'b0101);
    @(negedge Clk);
    chk("ret_addr1", 32'(Rd_Addr1), 32'd15);
    chk("st_addr2", 32'(Rd_Addr2), 32'd5);
    chk("dec_opcode3", 32'(Cu_Opcode), 32'd3);
    chk("dec_imm1", 32'(Cu_Imm), 32'd1);
    step();

    // Forwarding priority
    issue(32'h118, 32'h0808_C000, 4'b0000, 32'd5, 32'd7);
    Ex_Wr_i = 1; Ex_Rd_i = 2; Ex_Data_i = 32'hAA;
    Mem_Wr_i = 1; Mem_Rd_i = 2; Mem_Data_i = 32'hBB;
    expect_pkt(32'h118, 32'h0808_C000, 32'hAA, 32'd7, 32'd7, 4'b0000);
    step();
    Ex_Wr_i = 0;
    If_Pc_i = 32'h11C;
    expect_pkt(32'h11C, 32'h0808_C000, 32'hBB, 32'd7, 32'd7, 4'b0000);
    step();
    Ex_Wr_i = 1; Ex_Rd_i = 3;
    If_Pc_i = 32'h120;
    expect_pkt(32'h120, 32'h0808_C000, 32'hBB, 32'hAA, 32'hAA, 4'b0000);
    step();
    clr();

    // Load-use hazard on r4: one bubble, then MEM forwarding
    issue(32'h200, 32'h0810_0000, 4'b0000, 32'h99, 32'h0);
    Ex_Wr_i = 1; Ex_IsLd_i = 1; Ex_Rd_i = 4; Ex_Data_i = 32'hDEAD;
    @(negedge Clk);
    chk("hz_if_ready", 32'(If_Ready_o), 32'd0);
    chk("hz_cnt_before", 32'(Hz_Cnt_o), 32'd0);
    step();
    chk("hz_bubble", 32'(Of_Valid_o), 32'd0);
    chk("hz_cnt_one", 32'(Hz_Cnt_o), 32'd1);
    Ex_Wr_i = 0; Ex_IsLd_i = 0;
    Mem_Wr_i = 1; Mem_Rd_i = 4; Mem_Data_i = 32'h1234;
    expect_pkt(32'h200, 32'h0810_0000, 32'h1234, 32'h0, 32'h0, 4'b0000);
    @(negedge Clk);
    chk("hz_release_ready", 32'(If_Ready_o), 32'd1);
    step();
    chk("hz_accept_valid", 32'(Of_Valid_o), 32'd1);
    chk("hz_cnt_hold", 32'(Hz_Cnt_o), 32'd1);

    // Sustained hazard saturates the counter at 7
    Mem_Wr_i = 0;
    Ex_Wr_i = 1; Ex_IsLd_i = 1; Ex_Rd_i = 4;
    If_Pc_i = 32'h204;
    repeat (8) step();
    chk("hz_saturate", 32'(Hz_Cnt_o), 32'd7);
    chk("hz_stall_valid", 32'(Of_Valid_o), 32'd0);
    clr();

    // Backpressure for three cycles, then flush
    Of_Ready_i = 0;
    issue(32'h300, 32'h0808_C000, 4'b0000, 32'h31, 32'h32);
    step();
    issue(32'h304, 32'h0804_C000, 4'b0000, 32'h41, 32'h42);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("stall_valid", 32'(Of_Valid_o), 32'd1);
      chk("stall_pc", Of_Pc_o, 32'h300);
      chk("stall_a", Of_A_o, 32'h31);
      chk("stall_if_ready", 32'(If_Ready_o), 32'd0);
      step();
    end
    Flush_i = 1;
    @(negedge Clk);
    chk("flush_if_ready", 32'(If_Ready_o), 32'd1);
    step();
    clr();
    chk("flush_valid", 32'(Of_Valid_o), 32'd0);
    step();
    chk("flush_no_replay", 32'(Of_Valid_o), 32'd0);

    // Reset while a packet is held
    Of_Ready_i = 0;
    issue(32'h400, 32'h0808_C000, 4'b0000, 32'h51, 32'h52);
    step();
    If_Valid_i = 0;
    chk("pre_rst_valid", 32'(Of_Valid_o), 32'd1);
    chk("pre_rst_hz", 32'(Hz_Cnt_o), 32'd7);
    #2 Rst = 1;
    #1;
    chk("async_rst_valid", 32'(Of_Valid_o), 32'd0);
    chk("async_rst_hz", 32'(Hz_Cnt_o), 32'd0);
    chk("async_rst_a", Of_A_o, 32'd0);
    chk("async_rst_pc", Of_Pc_o, 32'd0);
    @(posedge Clk);
    #1 Rst = 0;
    Of_Ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_no_pkt", 32'(Of_Valid_o), 32'd0);
    end

    // Recovery: a fresh handshake goes through
    issue(32'h500, 32'h0808_C000, 4'b0000, 32'd1, 32'd2);
    expect_pkt(32'h500, 32'h0808_C000, 32'd1, 32'd2, 32'd2, 4'b0000);
    step();
    clr();
    repeat (2) step();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("sb_count", 32'(popped), 32'(pushed));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
